// File: rtl/onc_16_mem_sys.sv
// ONC-16 program-loading memory subsystem: instruction ROM, data RAM and run controller.
// Optional `ONC_16_LOAD_CHECKSUM_EN: the load_last beat carries a checksum instead of a word.
module onc_16_mem_sys #(
    parameter int unsigned INST_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned DMEM_AW     = 8,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned HALT_CYCLES = 4,
    parameter int unsigned MAX_CYCLES  = 100000
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
    input  logic [DATA_W-1:0] cpu_imem_addr,
    output logic [INST_W-1:0] cpu_imem_din,
    input  logic [DATA_W-1:0] cpu_dmem_addr,
    input  logic [DATA_W-1:0] cpu_dmem_dout,
    input  logic              cpu_dmem_we,
    output logic [DATA_W-1:0] cpu_dmem_din,
    output logic              cpu_n_rst,
    output logic              cpu_en,
    output logic              done,
    output logic              timeout,
    output logic              load_err,
    output logic [31:0]       cycle_cnt
);

    localparam int unsigned IMEM_DEPTH = 2 ** IMEM_AW;
    localparam int unsigned DMEM_DEPTH = 2 ** DMEM_AW;
    localparam int unsigned RST_CW     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned HALT_CW    = $clog2(HALT_CYCLES);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StLoad    = 3'd1;
    localparam logic [2:0] StRsthold = 3'd2;
    localparam logic [2:0] StRun     = 3'd3;
    localparam logic [2:0] StDone    = 3'd4;
    localparam logic [2:0] StErr     = 3'd5;

    logic [INST_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    logic [2:0]         state_q, state_d;
    logic [IMEM_AW-1:0] load_ptr_q, load_ptr_d;
    logic [RST_CW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [HALT_CW-1:0] same_cnt_q, same_cnt_d;
    logic [DATA_W-1:0]  prev_addr_q, prev_addr_d;
    logic               prev_valid_q, prev_valid_d;
    logic [31:0]        cycle_cnt_q, cycle_cnt_d;
    logic               timeout_q, timeout_d;
    logic               load_err_q, load_err_d;
`ifdef ONC_16_LOAD_CHECKSUM_EN
    logic [INST_W-1:0]  csum_q, csum_d;
`endif

    logic               handshake;
    logic               ptr_full;
    logic               last_ok;
    logic               imem_we;
    logic               dmem_we;
    logic [31:0]        cnt_inc;
    logic               addr_same;
    logic [HALT_CW-1:0] same_inc;
    logic               halt_hit;
    logic               to_hit;

    assign handshake = load_valid & load_ready;
    assign ptr_full  = (load_ptr_q == {IMEM_AW{1'b1}});

`ifdef ONC_16_LOAD_CHECKSUM_EN
    assign last_ok = (load_data == csum_q);
    assign imem_we = handshake & ~load_last;
`else
    assign last_ok = 1'b1;
    assign imem_we = handshake;
`endif

    assign dmem_we   = cpu_dmem_we & cpu_en;
    assign cnt_inc   = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    // First RUN cycle has no valid predecessor, so it never counts as a repeat.
    assign addr_same = prev_valid_q && (cpu_imem_addr == prev_addr_q);
    assign same_inc  = same_cnt_q + HALT_CW'(1);
    assign halt_hit  = addr_same && (same_inc == HALT_CW'(HALT_CYCLES - 1));
    assign to_hit    = (cnt_inc >= 32'(MAX_CYCLES));

    always_comb begin
        state_d      = state_q;
        load_ptr_d   = load_ptr_q;
        rst_cnt_d    = rst_cnt_q;
        same_cnt_d   = same_cnt_q;
        prev_addr_d  = prev_addr_q;
        prev_valid_d = prev_valid_q;
        cycle_cnt_d  = cycle_cnt_q;
        timeout_d    = timeout_q;
        load_err_d   = load_err_q;
`ifdef ONC_16_LOAD_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d     = StLoad;
                    load_ptr_d  = '0;
                    cycle_cnt_d = '0;
                    timeout_d   = 1'b0;
                    load_err_d  = 1'b0;
`ifdef ONC_16_LOAD_CHECKSUM_EN
                    csum_d      = '0;
`endif
                end
            end
            StLoad: begin
                if (handshake) begin
                    if (load_last) begin
                        if (last_ok) begin
                            state_d   = StRsthold;
                            rst_cnt_d = '0;
                        end else begin
                            state_d    = StErr;
                            load_err_d = 1'b1;
                        end
                    end else if (ptr_full) begin
                        state_d    = StErr;
                        load_err_d = 1'b1;
                    end else begin
                        load_ptr_d = load_ptr_q + IMEM_AW'(1);
`ifdef ONC_16_LOAD_CHECKSUM_EN
                        csum_d     = csum_q + load_data;
`endif
                    end
                end
            end
            StRsthold: begin
                prev_valid_d = 1'b0;
                same_cnt_d   = '0;
                if (rst_cnt_q == RST_CW'(RST_CYCLES - 1)) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CW'(1);
                end
            end
            StRun: begin
                cycle_cnt_d  = cnt_inc;
                prev_addr_d  = cpu_imem_addr;
                prev_valid_d = 1'b1;
                same_cnt_d   = addr_same ? same_inc : '0;
                if (halt_hit || to_hit) begin
                    state_d   = StDone;
                    timeout_d = to_hit;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= StIdle;
            load_ptr_q   <= '0;
            rst_cnt_q    <= '0;
            same_cnt_q   <= '0;
            prev_addr_q  <= '0;
            prev_valid_q <= 1'b0;
            cycle_cnt_q  <= '0;
            timeout_q    <= 1'b0;
            load_err_q   <= 1'b0;
`ifdef ONC_16_LOAD_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            load_ptr_q   <= load_ptr_d;
            rst_cnt_q    <= rst_cnt_d;
            same_cnt_q   <= same_cnt_d;
            prev_addr_q  <= prev_addr_d;
            prev_valid_q <= prev_valid_d;
            cycle_cnt_q  <= cycle_cnt_d;
            timeout_q    <= timeout_d;
            load_err_q   <= load_err_d;
`ifdef ONC_16_LOAD_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    // Arrays are intentionally left out of reset so a program survives rst and reload.
    always_ff @(posedge clock) begin
        if (imem_we) begin
            imem[load_ptr_q] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (dmem_we) begin
            dmem[cpu_dmem_addr[DMEM_AW-1:0]] <= cpu_dmem_dout;
        end
    end

    assign cpu_imem_din = imem[cpu_imem_addr[IMEM_AW-1:0]];
    assign cpu_dmem_din = dmem[cpu_dmem_addr[DMEM_AW-1:0]];

    assign load_ready = (state_q == StLoad);
    assign cpu_en     = (state_q == StRun);
    assign cpu_n_rst  = (state_q == StRun) || (state_q == StDone);
    assign done       = (state_q == StDone);
    assign timeout    = timeout_q;
    assign load_err   = load_err_q;
    assign cycle_cnt  = cycle_cnt_q;

    // Upper address bits only select aliases of the same word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_imem_addr[DATA_W-1:IMEM_AW], cpu_dmem_addr[DATA_W-1:DMEM_AW]};

endmodule

// File: tb/tb_onc_16_mem_sys.sv
// Randomized self-checking bench for onc_16_mem_sys against a behavioural memory/run model.
// Honours `ONC_16_LOAD_CHECKSUM_EN when compiled with it.
module tb_onc_16_mem_sys;

    localparam int unsigned MAXC  = 50;
    localparam int unsigned HALTC = 4;
    localparam int unsigned RSTC  = 2;

    logic        clock = 1'b0;
    logic        rst;
    logic        start;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic        load_last;
    logic [15:0] cpu_imem_addr;
    logic [15:0] cpu_imem_din;
    logic [15:0] cpu_dmem_addr;
    logic [15:0] cpu_dmem_dout;
    logic        cpu_dmem_we;
    logic [15:0] cpu_dmem_din;
    logic        cpu_n_rst;
    logic        cpu_en;
    logic        done;
    logic        timeout;
    logic        load_err;
    logic [31:0] cycle_cnt;

    always #5 clock = ~clock;

    onc_16_mem_sys #(
        .INST_W     (16),
        .DATA_W     (16),
        .IMEM_AW    (8),
        .DMEM_AW    (8),
        .RST_CYCLES (RSTC),
        .HALT_CYCLES(HALTC),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .start        (start),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .cpu_imem_addr(cpu_imem_addr),
        .cpu_imem_din (cpu_imem_din),
        .cpu_dmem_addr(cpu_dmem_addr),
        .cpu_dmem_dout(cpu_dmem_dout),
        .cpu_dmem_we  (cpu_dmem_we),
        .cpu_dmem_din (cpu_dmem_din),
        .cpu_n_rst    (cpu_n_rst),
        .cpu_en       (cpu_en),
        .done         (done),
        .timeout      (timeout),
        .load_err     (load_err),
        .cycle_cnt    (cycle_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memories; *_ok marks words whose contents the bench knows.
    logic [15:0] m_imem    [256];
    bit          m_imem_ok [256];
    logic [15:0] m_dmem    [256];
    bit          m_dmem_ok [256];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        check("ready_before_start", load_ready, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ready_after_start", load_ready, 1);
        check("flags_cleared", {done, timeout, load_err}, 0);
        check("cnt_cleared", cycle_cnt, 0);
    endtask

    task automatic load_prog(input logic [15:0] words[$], input bit use_last, input bit corrupt,
                             output bit ok);
        logic [15:0] beats[$];
        logic [15:0] sum;
        int          ptr;
        bit          fin;
        bit          is_last;
        bit          wr;
        beats = words;
        sum   = 16'h0;
        ptr   = 0;
        fin   = 1'b0;
        ok    = 1'b0;
`ifdef ONC_16_LOAD_CHECKSUM_EN
        if (use_last) begin
            logic [15:0] total;
            total = 16'h0;
            foreach (words[i]) total = total + words[i];
            beats.push_back(corrupt ? total + 16'h1 : total);
        end
`else
        if (corrupt) sum = 16'h0;
`endif
        for (int i = 0; i < beats.size() && !fin; i++) begin
            is_last = use_last && (i == beats.size() - 1);
            while ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                tick();
            end
            check("ready_in_load", load_ready, 1);
            load_valid = 1'b1;
            load_data  = beats[i];
            load_last  = is_last;
            tick();
            wr = 1'b1;
`ifdef ONC_16_LOAD_CHECKSUM_EN
            if (is_last) wr = 1'b0;
`endif
            if (wr) begin
                m_imem[ptr]    = beats[i];
                m_imem_ok[ptr] = 1'b1;
            end
            if (is_last) begin
                fin = 1'b1;
`ifdef ONC_16_LOAD_CHECKSUM_EN
                ok = (beats[i] == sum);
`else
                ok = 1'b1;
`endif
            end else if (ptr == 255) begin
                fin = 1'b1;
            end else begin
                sum = sum + beats[i];
                ptr++;
            end
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("load_err", load_err, {31'b0, !ok});
        if (!ok) begin
            check("err_cpu_en", cpu_en, 0);
            check("err_n_rst", cpu_n_rst, 0);
            check("err_ready", load_ready, 0);
        end
    endtask

    task automatic rsthold_check();
        for (int i = 0; i < RSTC; i++) begin
            check("rsthold_n_rst", cpu_n_rst, 0);
            check("rsthold_en", cpu_en, 0);
            tick();
        end
        check("run_n_rst", cpu_n_rst, 1);
        check("run_en", cpu_en, 1);
    endtask

    // mode 0: repeat last listed address, 1: always-new addresses, 2: random with repeats.
    task automatic run_prog(input logic [15:0] addrs[$], input int mode, input bit rand_mem);
        logic [15:0] hist[$];
        logic [15:0] a, da, dd;
        bit          we, halt, to, fin;
        int          cnt;
        fin = 1'b0;
        cnt = 0;
        for (int k = 0; k < MAXC + 2 && !fin; k++) begin
            if (k < addrs.size()) a = addrs[k];
            else if (mode == 0) a = addrs[addrs.size() - 1];
            else if (mode == 1) a = 16'(k * 3 + 1);
            else if (hist.size() > 0 && $urandom_range(0, 2) == 0) a = hist[hist.size() - 1];
            else a = 16'($urandom_range(0, 15));
            if (rand_mem) begin
                we = 1'($urandom_range(0, 1));
                da = {8'($urandom), 4'h0, 4'($urandom_range(0, 15))};
                dd = 16'($urandom);
            end else begin
                we = (k == 0);
                da = 16'h0105;
                dd = 16'h1234;
            end
            cpu_imem_addr = a;
            cpu_dmem_addr = da;
            cpu_dmem_dout = dd;
            cpu_dmem_we   = we;
            start         = ($urandom_range(0, 7) == 0);
            #1;
            if (m_imem_ok[a[7:0]]) check("imem_read", cpu_imem_din, m_imem[a[7:0]]);
            if (m_dmem_ok[da[7:0]]) check("dmem_read", cpu_dmem_din, m_dmem[da[7:0]]);
            check("run_cpu_en", cpu_en, 1);
            tick();
            if (we) begin
                m_dmem[da[7:0]]    = dd;
                m_dmem_ok[da[7:0]] = 1'b1;
            end
            hist.push_back(a);
            cnt  = k + 1;
            halt = 1'b0;
            if (hist.size() >= HALTC) begin
                halt = 1'b1;
                for (int j = 1; j < HALTC; j++) begin
                    if (hist[hist.size() - 1 - j] != a) halt = 1'b0;
                end
            end
            to = (cnt >= MAXC);
            if (halt || to) begin
                fin = 1'b1;
                check("done_set", done, 1);
                check("timeout_flag", timeout, {31'b0, to});
                check("cycle_cnt_end", cycle_cnt, cnt);
                check("done_cpu_en", cpu_en, 0);
                check("done_n_rst", cpu_n_rst, 1);
            end else begin
                check("done_clear", done, 0);
                check("cycle_cnt_run", cycle_cnt, cnt);
            end
        end
        start       = 1'b0;
        cpu_dmem_we = 1'b0;
        tick();
        tick();
        check("cnt_frozen", cycle_cnt, cnt);
        check("done_held", done, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] q[$];
        logic [15:0] empty_q[$];
        bit          ok;

        rst           = 1'b1;
        start         = 1'b0;
        load_valid    = 1'b0;
        load_data     = 16'h0;
        load_last     = 1'b0;
        cpu_imem_addr = 16'h0;
        cpu_dmem_addr = 16'h0;
        cpu_dmem_dout = 16'h0;
        cpu_dmem_we   = 1'b0;

        // Reset and idle.
        repeat (3) tick();
        rst = 1'b0;
        check("rst_n_rst", cpu_n_rst, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_ready", load_ready, 0);
        check("rst_cnt", cycle_cnt, 0);
        check("rst_flags", {done, timeout, load_err}, 0);
        tick();
        check("idle_ready", load_ready, 0);

        // Five-word program ending in jump-to-self at address 4.
        do_start();
        q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hC004};
        load_prog(q, 1'b1, 1'b0, ok);
        rsthold_check();
        q = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004};
        run_prog(q, 0, 1'b0);
        check("halt_cnt", cycle_cnt, 8);
        check("halt_no_timeout", timeout, 0);
        cpu_imem_addr = 16'h0304;
        cpu_dmem_addr = 16'h0005;
        #1;
        check("imem_wrap", cpu_imem_din, 16'hC004);
        check("dmem_wrap", cpu_dmem_din, 16'h1234);
        cpu_dmem_dout = 16'hBEEF;
        cpu_dmem_we   = 1'b1;
        tick();
        cpu_dmem_we = 1'b0;
        #1;
        check("done_store_dropped", cpu_dmem_din, 16'h1234);

        // Overflow: 256 words with no last beat, then recover.
        do_start();
        q.delete();
        for (int i = 0; i < 256; i++) q.push_back(16'($urandom));
        load_prog(q, 1'b0, 1'b0, ok);
        check("overflow_err", load_err, 1);
        check("overflow_en", cpu_en, 0);
        do_start();
        q = '{16'hA001, 16'hA002, 16'hA003};
        load_prog(q, 1'b1, 1'b0, ok);
        rsthold_check();
        run_prog(empty_q, 2, 1'b1);

        // Timeout with ever-changing fetch addresses.
        do_start();
        q = '{16'h0F00, 16'h0F01};
        load_prog(q, 1'b1, 1'b0, ok);
        rsthold_check();
        run_prog(empty_q, 1, 1'b1);
        check("to_cnt", cycle_cnt, MAXC);
        check("to_flag", timeout, 1);

        // Halt and timeout on the same cycle.
        do_start();
        q = '{16'h1234};
        load_prog(q, 1'b1, 1'b0, ok);
        rsthold_check();
        q.delete();
        for (int i = 0; i < MAXC - HALTC; i++) q.push_back(16'(i));
        q.push_back(16'h0100);
        run_prog(q, 0, 1'b0);
        check("both_timeout", timeout, 1);
        check("both_cnt", cycle_cnt, MAXC);

        // Checksum load (a plain load when the checksum feature is off).
        do_start();
        q = '{16'h0001, 16'h0002};
        load_prog(q, 1'b1, 1'b1, ok);
`ifdef ONC_16_LOAD_CHECKSUM_EN
        check("csum_bad_err", load_err, 1);
        do_start();
        load_prog(q, 1'b1, 1'b0, ok);
        check("csum_good_ok", load_err, 0);
`endif
        rsthold_check();
        run_prog(empty_q, 2, 1'b1);

        // Reset in the middle of RUN.
        do_start();
        q = '{16'h5555, 16'h6666};
        load_prog(q, 1'b1, 1'b0, ok);
        rsthold_check();
        for (int k = 0; k < 3; k++) begin
            cpu_imem_addr = 16'(k + 40);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_en", cpu_en, 0);
        check("abort_n_rst", cpu_n_rst, 0);
        check("abort_cnt", cycle_cnt, 0);
        check("abort_flags", {done, timeout, load_err}, 0);

        // Randomized loads and runs.
        for (int it = 0; it < 16; it++) begin
            do_start();
            q.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++) q.push_back(16'($urandom));
            load_prog(q, 1'b1, ($urandom_range(0, 4) == 0), ok);
            if (ok) begin
                rsthold_check();
                run_prog(empty_q, ($urandom_range(0, 3) == 0) ? 1 : 2, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/onc_16_mem_sys.md
# onc_16_mem_sys

Program-loading memory subsystem for the ONC-16 core. It holds instruction ROM and data RAM, accepts a program over a valid/ready stream, and sequences the core through reset, run and halt. On halt it reports the cycle count and completion status. It sits beside `onc_16_pl` at the top level and replaces file-preloaded behavioural memories with synthesizable arrays plus a run controller.

## Interface
- INST_W, 16, instruction word width
- DATA_W, 16, data word / address width
- IMEM_AW, 8, instruction memory address bits (depth 2^IMEM_AW)
- DMEM_AW, 8, data memory address bits (depth 2^DMEM_AW)
- RST_CYCLES, 2, cycles `cpu_n_rst` is held low before run (≥1)
- HALT_CYCLES, 4, consecutive identical fetch addresses that signal halt (≥2)
- MAX_CYCLES, 100000, run-cycle timeout limit
- clock  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse: begin load (accepted in IDLE, DONE, ERR)
- load_valid  in  1  load word valid
- load_ready  out  1  load word accepted this cycle when valid&ready
- load_data  in  INST_W  program word
- load_last  in  1  marks final beat of program
- cpu_imem_addr  in  DATA_W  core fetch address
- cpu_imem_din  out  INST_W  instruction to core
- cpu_dmem_addr  in  DATA_W  core data address
- cpu_dmem_dout  in  DATA_W  core store data
- cpu_dmem_we  in  1  core store enable
- cpu_dmem_din  out  DATA_W  load data to core
- cpu_n_rst  out  1  active-low reset to core
- cpu_en  out  1  core enable
- done  out  1  run finished (halt or timeout)
- timeout  out  1  run ended by MAX_CYCLES
- load_err  out  1  program overflow or checksum mismatch
- cycle_cnt  out  32  cycles spent in RUN

## Operation
- States: IDLE, LOAD, RSTHOLD, RUN, DONE, ERR.
- IDLE: `start` → LOAD, clears load_ptr, cycle_cnt, done, timeout, load_err.
- LOAD: `load_ready`=1. Each handshake writes `imem[load_ptr]` and increments load_ptr. A handshake with `load_last` → RSTHOLD. A handshake at load_ptr = 2^IMEM_AW−1 without `load_last` → ERR with `load_err`=1; that word is written.
- RSTHOLD: `cpu_n_rst`=0 for RST_CYCLES cycles, then → RUN.
- RUN: `cpu_n_rst`=1, `cpu_en`=1, and cycle_cnt increments each cycle, saturating at 2^32−1.
  - If `cpu_imem_addr` equals the previous cycle's value for HALT_CYCLES−1 consecutive comparisons → DONE.
  - If cycle_cnt reaches MAX_CYCLES → DONE with `timeout`=1.
  - If both conditions hit in the same cycle, `timeout`=1.
- DONE: `cpu_en`=0, `cpu_n_rst`=1 (core state inspectable), `done`=1. `start` → LOAD.
- ERR: `cpu_en`=0, `cpu_n_rst`=0. `start` → LOAD.
- Memory reads are asynchronous: `cpu_imem_din`=imem[addr[IMEM_AW-1:0]] and `cpu_dmem_din`=dmem[addr[DMEM_AW-1:0]]. Upper address bits are ignored, so addresses wrap.
- Data writes happen at the rising edge only when `cpu_dmem_we` & `cpu_en`. Stores outside RUN are dropped.
- Read during write returns old data.
- Memory arrays are not cleared by `rst` or by reload.

## Timing
- Reset values: state=IDLE, `load_ready`=0, `cpu_n_rst`=0, `cpu_en`=0, `done`=0, `timeout`=0, `load_err`=0, `cycle_cnt`=0.
- `rst` mid-LOAD or mid-RUN aborts to IDLE on the next edge. The partial program stays in imem.
- Load throughput: one word per cycle. `load_ready` rises the cycle after `start` is sampled.
- Final load beat to first RUN cycle: RST_CYCLES+1 edges.
- `done` asserts the cycle after the halt or timeout condition is sampled. `cycle_cnt` freezes at that value.
- `start` is ignored in LOAD, RSTHOLD and RUN.

## Configuration
- `ONC_16_LOAD_CHECKSUM_EN`
  - Defined: the `load_last` beat carries a checksum, not a program word, and is not written. The checksum is the sum mod 2^INST_W of all preceding words in the load. A mismatch → ERR with `load_err`=1; a match → RSTHOLD.
  - Undefined: the `load_last` beat is an ordinary program word, written like the others, and no check is performed.

## Test plan
- Reset then idle: hold `rst` 3 cycles → `cpu_n_rst`=0, `cpu_en`=0, `load_ready`=0, `cycle_cnt`=0.
- Load of 5 words, last word is jump-to-self at address 4 → imem[0..4] match the loaded words. `cpu_n_rst` is low 2 cycles, RUN follows, and once the fetch address holds 4 for 4 cycles, `done`=1, `timeout`=0 and `cycle_cnt` is frozen.
- Load of 256 words with IMEM_AW=8 and no `load_last` → `load_err`=1 after the 256th handshake and `cpu_en`=0. A later `start` plus a valid load recovers.
- Program that loops forever over different addresses, with MAX_CYCLES=50 → `done`=1, `timeout`=1, `cycle_cnt`=50.
- Core store of 0x1234 to addr 0x0105 with DMEM_AW=8 → reading addr 0x0005 returns 0x1234. A store with `cpu_dmem_we`=1 during DONE leaves memory unchanged.
- With `ONC_16_LOAD_CHECKSUM_EN`: words 0x0001, 0x0002 then a checksum beat 0x0004 → `load_err`=1. Checksum 0x0003 → RUN starts.
